// File: rtl/iter_shifter.sv
// Sequential shift/rotate unit: SLL, SRL, SRA and ROR applied one bit per clock
// behind a start/busy/done handshake; result is read straight from the shift register.
module iter_shifter #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    state_t           state;
    state_t           next_state;
    shift_op_t        op_q;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] step_val;
    logic [SHW-1:0]   count;

    always_comb begin
        step_val = sreg;
        case (op_q)
            OP_SLL:  step_val = {sreg[WIDTH-2:0], 1'b0};
            OP_SRL:  step_val = {1'b0, sreg[WIDTH-1:1]};
            OP_SRA:  step_val = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
            OP_ROR:  step_val = {sreg[0], sreg[WIDTH-1:1]};
            default: step_val = sreg;
        endcase
    end

    // A zero shift amount skips SHIFT entirely so done follows acceptance by one edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count == SHW'(1)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            count <= '0;
            op_q  <= OP_SLL;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg  <= a;
                        count <= shamt;
                        op_q  <= shift_op_t'(op);
                    end
                end
                SHIFT: begin
                    sreg  <= step_val;
                    count <= count - SHW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = sreg;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter: hand-computed results, done latency,
// handshake corner cases and asynchronous reset abort.
module tb_iter_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int failures;

    iter_shifter #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .shamt  (shamt),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, expected);
        end
    endtask

    // Entered and left at #1 after a rising edge with the unit idle.
    task automatic applyStimulus(input string tag, input logic [31:0] a_in, input logic [4:0] sh_in,
                                 input logic [1:0] op_in, input logic [31:0] expected);
        int lat;
        start = 1'b1;
        a     = a_in;
        shamt = sh_in;
        op    = op_in;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hFFFF_FFFF;
        shamt = 5'd0;
        op    = 2'b00;
        lat   = 1;
        checkOutput({tag, " busy_after_accept"}, {31'd0, busy}, 32'd1);
        while (!done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done) checkOutput({tag, " busy_during_shift"}, {31'd0, busy}, 32'd1);
        end
        checkOutput({tag, " latency"}, lat, 32'(sh_in) + 32'd1);
        checkOutput({tag, " result"}, result, expected);
        checkOutput({tag, " busy_at_done"}, {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, " done_width"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " result_hold"}, result, expected);
    endtask

    initial begin
        int lat;
        int spurious;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = 32'd0;
        shamt    = 5'd0;
        op       = 2'b00;

        #12;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("sll4", 32'h8000_0001, 5'd4, 2'b00, 32'h0000_0010);
        applyStimulus("sra31", 32'hF000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
        applyStimulus("srl31", 32'hF000_0000, 5'd31, 2'b01, 32'h0000_0001);
        applyStimulus("ror8", 32'h1234_5678, 5'd8, 2'b11, 32'h7812_3456);
        applyStimulus("sh0", 32'hDEAD_BEEF, 5'd0, 2'b10, 32'hDEAD_BEEF);
        applyStimulus("sra4neg", 32'h8000_0000, 5'd4, 2'b10, 32'hF800_0000);
        applyStimulus("srl4", 32'h8000_0000, 5'd4, 2'b01, 32'h0800_0000);
        applyStimulus("ror1", 32'h0000_0001, 5'd1, 2'b11, 32'h8000_0000);
        applyStimulus("sll31", 32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000);
        applyStimulus("sra30pos", 32'h7FFF_FFFF, 5'd30, 2'b10, 32'h0000_0001);
        applyStimulus("ror31", 32'hA5A5_A5A5, 5'd31, 2'b11, 32'h4B4B_4B4B);

        // A start pulse while shifting must not disturb the operation in flight.
        start = 1'b1; a = 32'h8000_0001; shamt = 5'd4; op = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 32'hFFFF_FFFF; shamt = 5'd0; op = 2'b11;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3;
        while (!done && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("ignore latency", lat, 32'd5);
        checkOutput("ignore result", result, 32'h0000_0010);
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) spurious++;
        end
        checkOutput("ignore no_extra_done", spurious, 32'd0);

        // Start held high: the second request is taken on the first idle edge after done.
        start = 1'b1; a = 32'h1234_5678; shamt = 5'd8; op = 2'b11;
        @(posedge clk); #1;
        a = 32'h0000_0003; shamt = 5'd2; op = 2'b00;
        lat = 1;
        while (!done && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("held first latency", lat, 32'd9);
        checkOutput("held first result", result, 32'h7812_3456);
        @(posedge clk); #1;
        checkOutput("held idle gap", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("held reaccept busy", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!done && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("held second latency", lat, 32'd3);
        checkOutput("held second result", result, 32'h0000_000C);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a long rotate aborts it without a done pulse.
        start = 1'b1; a = 32'h1234_5678; shamt = 5'd20; op = 2'b11;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done || busy) spurious++;
        end
        checkOutput("abort no_done", spurious, 32'd0);
        applyStimulus("post_reset", 32'h8000_0000, 5'd4, 2'b10, 32'hF800_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
